// File: rtl/tipi_pi_nib_master.sv
// tipi_pi_nib_master: Pi-side initiator for the TIPI 4-bit nibble bus.
// Ports:
//   clk, r_reset            - system clock, synchronous active-high reset
//   req_valid/ready/write/reg/data - single register request (RD/RC write, TD/TC read)
//   rsp_valid/data/err      - one-cycle completion pulse with read data or write echo
//   r_clk, r_nibrst         - nibble bus clock and nibble-counter reset strobe
//   r_nib_o/r_nib_oe/r_nib_i - shared nibble bus (drive value, drive enable, sampled value)
//   busy                    - inverse of req_ready
module tipi_pi_nib_master #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_TRIES = 8
) (
  input  logic       clk,
  input  logic       r_reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [1:0] req_reg,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       r_clk,
  output logic       r_nibrst,
  output logic [3:0] r_nib_o,
  output logic       r_nib_oe,
  input  logic [3:0] r_nib_i,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, NRST, CMD, TURN, HI, LO, CHECK, DONE} state_t;
  state_t state, next;
  logic [8:0] div;
  logic [3:0] tries;
  logic [7:0] smp, prev, res, wdata;
  logic [1:0] rg;
  logic wr, res_err, phase_end, hi_half, legal, settle;
  assign phase_end = div == 9'(2 * CLK_DIV - 1);
  assign hi_half = div >= 9'(CLK_DIV);
  assign legal = req_write ? ~req_reg[1] : req_reg[1];
  // a read settles once two consecutive attempts agree or the attempt budget is spent
  assign settle = tries != 4'd0 && (smp == prev || tries == 4'(MAX_TRIES - 1));
  assign req_ready = state == IDLE;
  assign busy = ~req_ready;
  always_ff @(posedge clk)
    state <= r_reset ? IDLE : next;
  always_comb begin
    next = state;
    r_clk = 1'b0;
    r_nibrst = 1'b0;
    r_nib_o = 4'd0;
    r_nib_oe = 1'b0;
    case (state)
      IDLE: next = req_valid ? (legal ? NRST : DONE) : IDLE;
      NRST: begin
        r_nibrst = 1'b1;
        next = phase_end ? CMD : NRST;
      end
      CMD: begin
        r_clk = hi_half;
        r_nib_oe = 1'b1;
        r_nib_o = {wr, 1'b0, rg};
        next = phase_end ? (wr ? HI : TURN) : CMD;
      end
      TURN: begin
        r_clk = hi_half;
        next = phase_end ? HI : TURN;
      end
      HI: begin
        r_clk = hi_half;
        r_nib_oe = wr;
        r_nib_o = wr ? wdata[7:4] : 4'd0;
        next = phase_end ? LO : HI;
      end
      LO: begin
        r_clk = hi_half;
        r_nib_oe = wr;
        r_nib_o = wr ? wdata[3:0] : 4'd0;
        next = phase_end ? (wr ? DONE : CHECK) : LO;
      end
      CHECK: next = settle ? DONE : NRST;
      DONE: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (r_reset) begin
      div <= '0;
      tries <= '0;
      smp <= '0;
      prev <= '0;
      res <= '0;
      res_err <= 1'b0;
      wr <= 1'b0;
      rg <= '0;
      wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= state == DONE;
      if (state == DONE) begin
        rsp_data <= res;
        rsp_err <= res_err;
      end
      div <= (state inside {NRST, CMD, TURN, HI, LO}) && !phase_end ? div + 9'd1 : 9'd0;
      if (state == IDLE && req_valid) begin
        wr <= req_write;
        rg <= req_reg;
        wdata <= req_data;
        res <= req_data;
        res_err <= ~legal;
        tries <= '0;
      end
      if (state == HI && phase_end) smp[7:4] <= r_nib_i;
      if (state == LO && phase_end) smp[3:0] <= r_nib_i;
      if (state == CHECK) begin
        if (settle) begin
          res <= smp;
          res_err <= smp != prev;
        end else begin
          prev <= smp;
          tries <= tries + 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tipi_pi_nib_master.sv
// tb_tipi_pi_nib_master: directed bench with a CPLD-style nibble responder model.
module tb_tipi_pi_nib_master;
  logic clk = 1'b0;
  logic r_reset = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0;
  logic [1:0] req_reg = 2'd0;
  logic [7:0] req_data = 8'd0;
  logic req_ready, rsp_valid, rsp_err, r_clk, r_nibrst, r_nib_oe, busy;
  logic [7:0] rsp_data;
  logic [3:0] r_nib_o;
  logic [3:0] nib_i = 4'd0;
  int checks = 0, errors = 0;
  logic [7:0] vals [0:63];
  logic [3:0] caps [0:7];
  logic oes [0:7];
  int att = 0, edges = 0, idx = 0;
  logic rclk_q = 1'b0, nrst_q = 1'b0;

  tipi_pi_nib_master #(.CLK_DIV(4), .MAX_TRIES(8)) dut (
    .clk(clk), .r_reset(r_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_reg(req_reg), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .r_clk(r_clk), .r_nibrst(r_nibrst), .r_nib_o(r_nib_o), .r_nib_oe(r_nib_oe),
    .r_nib_i(nib_i), .busy(busy)
  );

  always #5 clk = ~clk;

  // Responder: nibrst restarts the nibble index; each r_clk rise captures the
  // master nibble and, for reads, launches the TD/TC nibble for this attempt.
  always @(posedge clk) begin
    if (r_nibrst && !nrst_q) begin
      idx <= 0;
      att <= att + 1;
    end else if (r_clk && !rclk_q) begin
      caps[idx & 7] <= r_nib_o;
      oes[idx & 7] <= r_nib_oe;
      idx <= idx + 1;
      edges <= edges + 1;
      if (idx == 2) nib_i <= vals[(att - 1) & 63][7:4];
      if (idx == 3) nib_i <= vals[(att - 1) & 63][3:0];
    end
    nrst_q <= r_nibrst;
    rclk_q <= r_clk;
  end

  task automatic do_req(input logic w, input logic [1:0] rg, input logic [7:0] d, output int cyc);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_reg = rg;
    req_data = d;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!rsp_valid && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    r_reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (r_clk !== 1'b0) begin errors++; $display("FAIL reset_rclk got %b want 0", r_clk); end
    checks++; if (r_nibrst !== 1'b0) begin errors++; $display("FAIL reset_nibrst got %b want 0", r_nibrst); end
    checks++; if (r_nib_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", r_nib_oe); end
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_ready got %b/%b want 1/0", req_ready, busy); end
    checks++; if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp got %b/%h want 0/00", rsp_valid, rsp_data); end
    r_reset = 1'b0;
  endtask

  task automatic test_write;
    int cyc;
    do_req(1'b1, 2'd1, 8'hA5, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL write_latency got %0d want 33", cyc); end
    checks++; if (rsp_data !== 8'hA5 || rsp_err !== 1'b0) begin errors++; $display("FAIL write_rsp got %h/%b want a5/0", rsp_data, rsp_err); end
    checks++; if ({caps[0], caps[1], caps[2]} !== 12'h9A5) begin errors++; $display("FAIL write_nibbles got %h want 9a5", {caps[0], caps[1], caps[2]}); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL write_pulse got %b/%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_stable_read;
    int cyc, a0;
    a0 = att;
    vals[a0 & 63] = 8'h3C;
    vals[(a0 + 1) & 63] = 8'h3C;
    do_req(1'b0, 2'd2, 8'h00, cyc);
    checks++; if (cyc !== 83) begin errors++; $display("FAIL stable_latency got %0d want 83", cyc); end
    checks++; if (rsp_data !== 8'h3C || rsp_err !== 1'b0) begin errors++; $display("FAIL stable_rsp got %h/%b want 3c/0", rsp_data, rsp_err); end
    checks++; if (att - a0 !== 2) begin errors++; $display("FAIL stable_attempts got %0d want 2", att - a0); end
    checks++; if (caps[0] !== 4'h2) begin errors++; $display("FAIL stable_cmd got %h want 2", caps[0]); end
    checks++; if ({oes[1], oes[2], oes[3]} !== 3'b000) begin errors++; $display("FAIL stable_oe got %b want 000", {oes[1], oes[2], oes[3]}); end
  endtask

  task automatic test_changing_read;
    int cyc, a0;
    a0 = att;
    vals[a0 & 63] = 8'h11;
    vals[(a0 + 1) & 63] = 8'h22;
    vals[(a0 + 2) & 63] = 8'h22;
    do_req(1'b0, 2'd3, 8'h00, cyc);
    checks++; if (cyc !== 124) begin errors++; $display("FAIL change_latency got %0d want 124", cyc); end
    checks++; if (rsp_data !== 8'h22 || rsp_err !== 1'b0) begin errors++; $display("FAIL change_rsp got %h/%b want 22/0", rsp_data, rsp_err); end
    checks++; if (att - a0 !== 3 || caps[0] !== 4'h3) begin errors++; $display("FAIL change_attempts got %0d/%h want 3/3", att - a0, caps[0]); end
  endtask

  task automatic test_unstable_read;
    int cyc, a0;
    a0 = att;
    for (int i = 0; i < 8; i++) vals[(a0 + i) & 63] = 8'(i + 1);
    do_req(1'b0, 2'd2, 8'h00, cyc);
    checks++; if (cyc !== 329) begin errors++; $display("FAIL unstable_latency got %0d want 329", cyc); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 8'h08) begin errors++; $display("FAIL unstable_rsp got %h/%b want 08/1", rsp_data, rsp_err); end
    checks++; if (att - a0 !== 8) begin errors++; $display("FAIL unstable_attempts got %0d want 8", att - a0); end
  endtask

  task automatic test_illegal;
    int cyc, e0, a0;
    e0 = edges;
    a0 = att;
    do_req(1'b1, 2'd2, 8'h55, cyc);
    checks++; if (cyc !== 1 || rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_write got %0d/%b want 1/1", cyc, rsp_err); end
    do_req(1'b0, 2'd0, 8'h00, cyc);
    checks++; if (cyc !== 1 || rsp_err !== 1'b1) begin errors++; $display("FAIL illegal_read got %0d/%b want 1/1", cyc, rsp_err); end
    checks++; if (edges !== e0 || att !== a0) begin errors++; $display("FAIL illegal_bus got %0d/%0d edges want 0/0", edges - e0, att - a0); end
  endtask

  task automatic test_abort;
    int cyc, seen;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_reg = 2'd1;
    req_data = 8'hC3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (r_nib_oe !== 1'b1 || r_nib_o !== 4'hC) begin errors++; $display("FAIL abort_in_hi got %b/%h want 1/c", r_nib_oe, r_nib_o); end
    r_reset = 1'b1;
    @(negedge clk);
    r_reset = 1'b0;
    checks++; if ({r_clk, r_nibrst, r_nib_oe, r_nib_o} !== 7'd0 || req_ready !== 1'b1) begin errors++; $display("FAIL abort_idle got %b%b%b%h/%b want 0000/1", r_clk, r_nibrst, r_nib_oe, r_nib_o, req_ready); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_rsp got %0d want 0", seen); end
    do_req(1'b1, 2'd0, 8'h00, cyc);
    checks++; if (cyc !== 33 || rsp_data !== 8'h00 || rsp_err !== 1'b0) begin errors++; $display("FAIL abort_recover got %0d/%h/%b want 33/00/0", cyc, rsp_data, rsp_err); end
    checks++; if ({caps[0], caps[1], caps[2]} !== 12'h800) begin errors++; $display("FAIL abort_nibbles got %h want 800", {caps[0], caps[1], caps[2]}); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) vals[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      caps[i] = 4'h0;
      oes[i] = 1'b0;
    end
    test_reset;
    test_write;
    test_stable_read;
    test_changing_read;
    test_unstable_read;
    test_illegal;
    test_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
